// File: rtl/branch_predict_unit.sv
// Branch prediction and resolution: a 2-bit BHT feeds fetch, and execute
// resolves branches, drives the PC mux and kills, and keeps perf counters.
module branch_predict_unit #(
  parameter int XLEN              = 32,
  parameter int BHT_ENTRIES       = 64,
  parameter int FENCE_KILL_CYCLES = 2,
  parameter int PERF_WIDTH        = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [XLEN-1:0]       if_pc,
  output logic                  if_pred_taken,
  input  logic                  ex_valid,
  input  logic [XLEN-1:0]       ex_pc,
  input  logic [3:0]            ex_br_type,
  input  logic                  ex_br_eq,
  input  logic                  ex_br_lt,
  input  logic                  ex_br_ltu,
  input  logic                  ex_pred_taken,
  input  logic                  pipeline_kill,
  input  logic                  fence_i,
  output logic [2:0]            pc_sel,
  output logic                  if_kill,
  output logic                  dec_kill,
  output logic [PERF_WIDTH-1:0] perf_branches,
  output logic [PERF_WIDTH-1:0] perf_mispredicts
);

  localparam int IDX_W = $clog2(BHT_ENTRIES);

  localparam logic [3:0] BR_N   = 4'd0;
  localparam logic [3:0] BR_NE  = 4'd1;
  localparam logic [3:0] BR_EQ  = 4'd2;
  localparam logic [3:0] BR_GE  = 4'd3;
  localparam logic [3:0] BR_GEU = 4'd4;
  localparam logic [3:0] BR_LT  = 4'd5;
  localparam logic [3:0] BR_LTU = 4'd6;
  localparam logic [3:0] BR_J   = 4'd7;
  localparam logic [3:0] BR_JR  = 4'd8;

  localparam logic [2:0] PC_4     = 3'd0;
  localparam logic [2:0] PC_BRJMP = 3'd1;
  localparam logic [2:0] PC_JALR  = 3'd2;
  localparam logic [2:0] PC_EXC   = 3'd3;
  localparam logic [2:0] PC_EX4   = 3'd4;

  localparam logic [3:0] FENCE_LOAD = 4'(FENCE_KILL_CYCLES);

  logic [1:0]            bht_q [BHT_ENTRIES];
  logic [1:0]            bht_cur;
  logic [1:0]            bht_d;
  logic [IDX_W-1:0]      if_idx;
  logic [IDX_W-1:0]      ex_idx;
  logic [3:0]            fence_cnt_q;
  logic [3:0]            fence_cnt_d;
  logic [PERF_WIDTH-1:0] perf_br_q;
  logic [PERF_WIDTH-1:0] perf_br_d;
  logic [PERF_WIDTH-1:0] perf_mis_q;
  logic [PERF_WIDTH-1:0] perf_mis_d;
  logic                  is_cond;
  logic                  is_j;
  logic                  is_jr;
  logic                  taken;
  logic                  upd;
  logic                  mispred;
  logic                  unused_pc_bits;

  assign if_idx = if_pc[IDX_W+1:2];
  assign ex_idx = ex_pc[IDX_W+1:2];

  assign unused_pc_bits = ^{if_pc[XLEN-1:IDX_W+2], if_pc[1:0],
                            ex_pc[XLEN-1:IDX_W+2], ex_pc[1:0]};

  // Old table contents are read even when execute writes the same entry.
  assign if_pred_taken = bht_q[if_idx][1];

  always_comb begin
    taken   = 1'b0;
    is_cond = 1'b0;
    unique case (ex_br_type)
      BR_NE:   begin is_cond = 1'b1; taken = !ex_br_eq;  end
      BR_EQ:   begin is_cond = 1'b1; taken = ex_br_eq;   end
      BR_GE:   begin is_cond = 1'b1; taken = !ex_br_lt;  end
      BR_GEU:  begin is_cond = 1'b1; taken = !ex_br_ltu; end
      BR_LT:   begin is_cond = 1'b1; taken = ex_br_lt;   end
      BR_LTU:  begin is_cond = 1'b1; taken = ex_br_ltu;  end
      default: begin is_cond = 1'b0; taken = 1'b0;       end
    endcase
  end

  assign is_j    = (ex_br_type == BR_J);
  assign is_jr   = (ex_br_type == BR_JR);
  assign upd     = ex_valid && is_cond && !pipeline_kill;
  assign mispred = (taken != ex_pred_taken);

  always_comb begin
    pc_sel = PC_4;
    if (pipeline_kill) begin
      pc_sel = PC_EXC;
    end else if (ex_valid && ex_br_type != BR_N) begin
      unique case (1'b1)
        is_j:                             pc_sel = PC_BRJMP;
        is_jr:                            pc_sel = PC_JALR;
        is_cond && taken && !ex_pred_taken: pc_sel = PC_BRJMP;
        is_cond && !taken && ex_pred_taken: pc_sel = PC_EX4;
        default:                          pc_sel = PC_4;
      endcase
    end
  end

  assign dec_kill = (pc_sel != PC_4);
  assign if_kill  = dec_kill | fence_i | (fence_cnt_q != 4'd0);

  always_comb begin
    fence_cnt_d = fence_cnt_q;
    if (fence_i)
      fence_cnt_d = FENCE_LOAD;
    else if (fence_cnt_q != 4'd0)
      fence_cnt_d = fence_cnt_q - 4'd1;
  end

  always_comb begin
    bht_cur = bht_q[ex_idx];
    bht_d   = bht_cur;
    if (taken) begin
      if (bht_cur != 2'b11) bht_d = bht_cur + 2'd1;
    end else begin
      if (bht_cur != 2'b00) bht_d = bht_cur - 2'd1;
    end
  end

  always_comb begin
    perf_br_d  = perf_br_q;
    perf_mis_d = perf_mis_q;
    if (upd) begin
      if (perf_br_q != '1)
        perf_br_d = perf_br_q + 1'b1;
      if (mispred && perf_mis_q != '1)
        perf_mis_d = perf_mis_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BHT_ENTRIES; i++)
        bht_q[i] <= 2'b01;
    end else if (upd) begin
      bht_q[ex_idx] <= bht_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fence_cnt_q <= 4'd0;
      perf_br_q   <= '0;
      perf_mis_q  <= '0;
    end else begin
      fence_cnt_q <= fence_cnt_d;
      perf_br_q   <= perf_br_d;
      perf_mis_q  <= perf_mis_d;
    end
  end

  assign perf_branches    = perf_br_q;
  assign perf_mispredicts = perf_mis_q;

endmodule

// File: tb/tb_branch_predict_unit.sv
// Directed bench for branch_predict_unit with 4-bit perf counters.
module tb_branch_predict_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] if_pc;
  logic        if_pred_taken;
  logic        ex_valid;
  logic [31:0] ex_pc;
  logic [3:0]  ex_br_type;
  logic        ex_br_eq;
  logic        ex_br_lt;
  logic        ex_br_ltu;
  logic        ex_pred_taken;
  logic        pipeline_kill;
  logic        fence_i;
  logic [2:0]  pc_sel;
  logic        if_kill;
  logic        dec_kill;
  logic [3:0]  perf_branches;
  logic [3:0]  perf_mispredicts;

  int tests  = 0;
  int failed = 0;

  always #5 clk = ~clk;

  branch_predict_unit #(
    .XLEN(32),
    .BHT_ENTRIES(64),
    .FENCE_KILL_CYCLES(2),
    .PERF_WIDTH(4)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .if_pc(if_pc),
    .if_pred_taken(if_pred_taken),
    .ex_valid(ex_valid),
    .ex_pc(ex_pc),
    .ex_br_type(ex_br_type),
    .ex_br_eq(ex_br_eq),
    .ex_br_lt(ex_br_lt),
    .ex_br_ltu(ex_br_ltu),
    .ex_pred_taken(ex_pred_taken),
    .pipeline_kill(pipeline_kill),
    .fence_i(fence_i),
    .pc_sel(pc_sel),
    .if_kill(if_kill),
    .dec_kill(dec_kill),
    .perf_branches(perf_branches),
    .perf_mispredicts(perf_mispredicts)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    ex_valid      = 1'b0;
    ex_pc         = 32'h0;
    ex_br_type    = 4'd0;
    ex_br_eq      = 1'b0;
    ex_br_lt      = 1'b0;
    ex_br_ltu     = 1'b0;
    ex_pred_taken = 1'b0;
    pipeline_kill = 1'b0;
    fence_i       = 1'b0;
  endtask

  task automatic resolve(input logic [31:0] pc, input logic [3:0] t,
                         input logic eq, input logic lt,
                         input logic ltu, input logic pred);
    ex_valid      = 1'b1;
    ex_pc         = pc;
    ex_br_type    = t;
    ex_br_eq      = eq;
    ex_br_lt      = lt;
    ex_br_ltu     = ltu;
    ex_pred_taken = pred;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic perf(input int pb, input int pm);
    chk("perf_branches", 32'(perf_branches), 32'(pb));
    chk("perf_mispredicts", 32'(perf_mispredicts), 32'(pm));
  endtask

  initial begin
    idle();
    if_pc = 32'h100;
    rst_n = 1'b0;
    #1;
    chk("rst_pred", 32'(if_pred_taken), 32'd0);
    chk("rst_pc_sel", 32'(pc_sel), 32'd0);
    chk("rst_if_kill", 32'(if_kill), 32'd0);
    chk("rst_dec_kill", 32'(dec_kill), 32'd0);
    perf(0, 0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // First BEQ taken, predicted not-taken
    resolve(32'h100, 4'd2, 1'b1, 1'b0, 1'b0, 1'b0);
    #1;
    chk("beq1_pred_old", 32'(if_pred_taken), 32'd0);
    chk("beq1_pc_sel", 32'(pc_sel), 32'd1);
    chk("beq1_if_kill", 32'(if_kill), 32'd1);
    chk("beq1_dec_kill", 32'(dec_kill), 32'd1);
    tick();
    #1;
    chk("beq1_pred_new", 32'(if_pred_taken), 32'd1);
    chk("idle_pc_sel", 32'(pc_sel), 32'd0);
    chk("idle_if_kill", 32'(if_kill), 32'd0);
    perf(1, 1);

    for (int i = 0; i < 4; i++) begin
      resolve(32'h100, 4'd2, 1'b1, 1'b0, 1'b0, 1'b1);
      #1;
      chk("train_pc_sel", 32'(pc_sel), 32'd0);
      tick();
    end
    perf(5, 1);

    resolve(32'h100, 4'd2, 1'b0, 1'b0, 1'b0, 1'b1);
    #1;
    chk("nt_pc_sel", 32'(pc_sel), 32'd4);
    chk("nt_dec_kill", 32'(dec_kill), 32'd1);
    tick();
    #1;
    chk("nt_pred_still1", 32'(if_pred_taken), 32'd1);
    resolve(32'h100, 4'd2, 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    #1;
    chk("sat_then_2nt_pred", 32'(if_pred_taken), 32'd0);
    perf(7, 3);

    // fence.i shadow
    fence_i = 1'b1;
    #1;
    chk("fence_dec_kill", 32'(dec_kill), 32'd0);
    chk("fence_pc_sel", 32'(pc_sel), 32'd0);
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("fence_if_kill", 32'(if_kill), (i < 3) ? 32'd1 : 32'd0);
      chk("fence_dec_kill_sh", 32'(dec_kill), 32'd0);
      tick();
    end

    // Killed mispredicting BNE: no training, no counting
    resolve(32'h100, 4'd1, 1'b0, 1'b0, 1'b0, 1'b0);
    pipeline_kill = 1'b1;
    #1;
    chk("kill_pc_sel", 32'(pc_sel), 32'd3);
    chk("kill_dec_kill", 32'(dec_kill), 32'd1);
    tick();
    #1;
    chk("kill_no_train", 32'(if_pred_taken), 32'd0);
    perf(7, 3);

    resolve(32'h100, 4'd7, 1'b1, 1'b0, 1'b0, 1'b0);
    #1;
    chk("j_pc_sel", 32'(pc_sel), 32'd1);
    tick();
    resolve(32'h100, 4'd8, 1'b1, 1'b0, 1'b0, 1'b0);
    #1;
    chk("jr_pc_sel", 32'(pc_sel), 32'd2);
    tick();
    resolve(32'h100, 4'd9, 1'b1, 1'b1, 1'b1, 1'b1);
    #1;
    chk("type9_pc_sel", 32'(pc_sel), 32'd0);
    tick();
    resolve(32'h100, 4'd2, 1'b1, 1'b0, 1'b0, 1'b0);
    ex_valid = 1'b0;
    #1;
    chk("novalid_pc_sel", 32'(pc_sel), 32'd0);
    chk("novalid_if_kill", 32'(if_kill), 32'd0);
    tick();
    #1;
    chk("jumps_no_train", 32'(if_pred_taken), 32'd0);
    perf(7, 3);

    // Aliasing 0x200 onto 0x100 with same-cycle read
    resolve(32'h200, 4'd5, 1'b0, 1'b1, 1'b0, 1'b0);
    #1;
    chk("blt_pc_sel", 32'(pc_sel), 32'd1);
    chk("alias_same_cycle", 32'(if_pred_taken), 32'd0);
    tick();
    #1;
    chk("alias_pred", 32'(if_pred_taken), 32'd1);
    perf(8, 4);

    // Decode of the remaining compare types, pred=0
    resolve(32'h10C, 4'd1, 1'b1, 1'b0, 1'b0, 1'b0);
    #1; chk("bne_eq", 32'(pc_sel), 32'd0); tick();
    resolve(32'h10C, 4'd3, 1'b0, 1'b1, 1'b0, 1'b0);
    #1; chk("bge_lt", 32'(pc_sel), 32'd0); tick();
    resolve(32'h10C, 4'd4, 1'b0, 1'b1, 1'b0, 1'b0);
    #1; chk("bgeu_nltu", 32'(pc_sel), 32'd1); tick();
    resolve(32'h10C, 4'd5, 1'b0, 1'b0, 1'b1, 1'b0);
    #1; chk("blt_ltu_only", 32'(pc_sel), 32'd0); tick();
    resolve(32'h10C, 4'd6, 1'b0, 1'b0, 1'b1, 1'b0);
    #1; chk("bltu_ltu", 32'(pc_sel), 32'd1); tick();
    resolve(32'h10C, 4'd4, 1'b0, 1'b0, 1'b1, 1'b0);
    #1; chk("bgeu_ltu", 32'(pc_sel), 32'd0); tick();
    perf(14, 6);

    // Saturation of 4-bit perf counters
    for (int i = 0; i < 20; i++) begin
      resolve(32'h100, 4'd2, 1'b1, 1'b0, 1'b0, 1'b0);
      tick();
    end
    #1;
    perf(15, 15);
    if_pc = 32'h100;
    #1;
    chk("trained_pred", 32'(if_pred_taken), 32'd1);

    // Reset mid-stream during a fence.i shadow
    fence_i = 1'b1;
    tick();
    rst_n = 1'b0;
    #1;
    chk("mid_rst_if_kill", 32'(if_kill), 32'd0);
    chk("mid_rst_pred", 32'(if_pred_taken), 32'd0);
    perf(0, 0);
    tick();
    rst_n = 1'b1;
    tick();
    #1;
    chk("post_rst_if_kill", 32'(if_kill), 32'd0);
    chk("post_rst_pred100", 32'(if_pred_taken), 32'd0);
    if_pc = 32'h10C;
    #1;
    chk("post_rst_pred10c", 32'(if_pred_taken), 32'd0);
    perf(0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/branch_predict_unit.md
Name: branch_predict_unit

Overview:
- Parametrised successor to the core's branch-resolution logic.
- Adds a 2-bit saturating branch history table (BHT) indexed by fetch PC, so fetch can predict conditional branches.
- Resolves branches in execute against the carried prediction and redirects only on mispredict, jump or exception.
- Extends the fence.i instruction-fetch kill shadow to a configurable depth and keeps saturating performance counters.
- Sits between fetch (predict port) and execute (resolve port); drives the PC mux select and the kill signals.

Parameters:
- XLEN, 32, PC width.
- BHT_ENTRIES, 64, number of 2-bit counters; must be a power of 2, at least 2.
- FENCE_KILL_CYCLES, 2, number of cycles if_kill stays high after fence_i deasserts; range 0..15.
- PERF_WIDTH, 32, width of the performance counters.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- if_pc  in  XLEN  fetch PC to predict.
- if_pred_taken  out  1  prediction for if_pc (combinational).
- ex_valid  in  1  a branch or jump is resolving in execute this cycle.
- ex_pc  in  XLEN  PC of the resolving instruction.
- ex_br_type  in  4  BR_N=0, NE=1, EQ=2, GE=3, GEU=4, LT=5, LTU=6, J=7, JR=8.
- ex_br_eq / ex_br_lt / ex_br_ltu  in  1 each  comparator results.
- ex_pred_taken  in  1  prediction carried down the pipe with the instruction.
- pipeline_kill  in  1  exception or flush.
- fence_i  in  1  fence.i is in execute.
- pc_sel  out  3  PC_4=0, PC_BRJMP=1, PC_JALR=2, PC_EXC=3, PC_EX4=4 (ex_pc+4 recovery).
- if_kill  out  1  kill the fetch stage.
- dec_kill  out  1  kill the decode stage.
- perf_branches  out  PERF_WIDTH  count of resolved conditional branches.
- perf_mispredicts  out  PERF_WIDTH  count of conditional mispredicts.

Behaviour:
- Index: idx = pc[log2(BHT_ENTRIES)+1:2].
- Prediction: if_pred_taken = bht[idx(if_pc)][1]. Read is combinational and read-before-write: a same-cycle update to the same entry is not visible until the next cycle.
- Conditional branch: ex_br_type in 1..6 with ex_valid=1. Actual taken follows the usual semantics (NE: !eq; EQ: eq; GE: !lt; GEU: !ltu; LT: lt; LTU: ltu).
- pc_sel priority, combinational:
  - pipeline_kill -> PC_EXC.
  - else !ex_valid or BR_N -> PC_4.
  - else J -> PC_BRJMP; JR -> PC_JALR.
  - else conditional, taken and !pred -> PC_BRJMP.
  - else conditional, !taken and pred -> PC_EX4.
  - else PC_4 (correct prediction).
  - Types 9..15 -> PC_4.
- dec_kill = (pc_sel != PC_4).
- if_kill = (pc_sel != PC_4) | fence_i | (fence_cnt != 0).
- fence_cnt, 4-bit:
  - loads FENCE_KILL_CYCLES in every cycle fence_i=1;
  - else decrements when nonzero;
  - holds at 0.
  - With FENCE_KILL_CYCLES=0, if_kill follows fence_i only.
- BHT update, on posedge for a conditional branch with !pipeline_kill:
  - taken: counter increments, saturating at 3;
  - not taken: counter decrements, saturating at 0.
  - J, JR and killed instructions never update.
- Perf counters, same enable as the BHT update:
  - perf_branches += 1;
  - perf_mispredicts += 1 if (taken != ex_pred_taken).
  - Both saturate at all-ones and never wrap.
- Reset (async assert, sync deassert is the integrator's duty):
  - all BHT entries = 2'b01 (weakly not-taken);
  - fence_cnt = 0; perf counters = 0.
  - if_pred_taken = 0; pc_sel = PC_4, if_kill = 0, dec_kill = 0, given idle inputs.
  - Reset mid-operation discards all training and any in-progress kill shadow.
- fence_i concurrent with a redirect: both effects apply; pc_sel follows the priority list.

Test Plan:
- Reset, then if_pc=0x100 -> if_pred_taken=0. BEQ at 0x100 with eq=1, pred=0 -> pc_sel=1, if_kill=dec_kill=1. Next cycle if_pc=0x100 -> pred=1 (counter 2).
- Train BEQ at 0x100 taken four times -> counter saturates at 3. One not-taken resolve with pred=1 -> pc_sel=4, counter 2, prediction still 1.
- fence_i high for 1 cycle, FENCE_KILL_CYCLES=2 -> if_kill high for exactly 3 cycles, dec_kill stays 0.
- pipeline_kill with a mispredicting BNE -> pc_sel=3; BHT entry and perf counters unchanged.
- PCs 0x100 and 0x200 (BHT_ENTRIES=64, same idx) -> aliasing: training one changes the prediction for the other. Same-cycle update and lookup -> old value returned.
- PERF_WIDTH=4: 20 mispredicting branches -> both counters hold at 15. Assert rst_n mid-stream -> counters 0, all entries predict 0.
